// File: rtl/mult_seq_pipe.sv
// mult_seq_pipe: sequential shift-add integer multiplier, signed or unsigned
// per operation, retiring STEP multiplier bits per clock.
//   clock     : sole clock, rising edge
//   reset     : synchronous, active-high; aborts any in-flight operation
//   start     : request, sampled only while idle
//   is_signed : 1 = two's complement operands, captured with start
//   op_a/op_b : multiplicand / multiplier, captured with start
//   busy      : high while an operation is in flight
//   done      : one-cycle pulse, product/overflow valid
//   product   : full 2*WIDTH product, held until the next result or reset
//   overflow  : product does not fit in WIDTH bits in the selected mode
module mult_seq_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(N + 1);

  // Reject illegal configurations at elaboration.
  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0 || WIDTH < 2) begin : g_bad_param
      $error("mult_seq_pipe: illegal WIDTH/STEP combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state;
  logic              mode_signed;
  logic              neg;
  logic [WIDTH-1:0]  mplier;
  logic [PW-1:0]     a_sh;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     count;

  logic [WIDTH-1:0]  mag_a_c;
  logic [WIDTH-1:0]  mag_b_c;
  logic [PW-1:0]     pp_c;
  logic [PW-1:0]     fixed_c;
  logic              ovf_c;

  // Operand magnitudes; -2^(WIDTH-1) negates onto itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    mag_a_c = op_a;
    mag_b_c = op_b;
    if (is_signed && op_a[WIDTH-1]) mag_a_c = -op_a;
    if (is_signed && op_b[WIDTH-1]) mag_b_c = -op_b;
  end

  // Partial product for the current STEP-bit multiplier digit; a_sh already
  // carries the positional shift.
  always_comb begin
    pp_c = a_sh * PW'(mplier[STEP-1:0]);
  end

  // Sign fix-up of the magnitude product and the range check on the result.
  always_comb begin
    fixed_c = neg ? -acc : acc;
    if (mode_signed)
      ovf_c = !((&fixed_c[PW-1:WIDTH-1]) || !(|fixed_c[PW-1:WIDTH-1]));
    else
      ovf_c = |fixed_c[PW-1:WIDTH];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      product     <= '0;
      overflow    <= 1'b0;
      mode_signed <= 1'b0;
      neg         <= 1'b0;
      mplier      <= '0;
      a_sh        <= '0;
      acc         <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_signed <= is_signed;
            neg         <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            a_sh        <= PW'(mag_a_c);
            mplier      <= mag_b_c;
            acc         <= '0;
            count       <= CW'(N);
            busy        <= 1'b1;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc + pp_c;
          a_sh   <= a_sh << STEP;
          mplier <= mplier >> STEP;
          count  <= count - CW'(1);
          if (count == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          product  <= fixed_c;
          overflow <= ovf_c;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_pipe.sv
// Directed and exhaustive checks of mult_seq_pipe across WIDTH/STEP variants.
module tb_mult_seq_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // WIDTH=8 instances: index 0 is STEP=1, index 1 is STEP=4.
  logic [1:0]  st8, bz8, dn8, ov8;
  logic        sg8;
  logic [7:0]  a8, b8;
  logic [15:0] pr8 [2];

  // WIDTH=4 instances: index g is STEP=1<<g.
  logic [2:0]  st4, bz4, dn4, ov4;
  logic        sg4;
  logic [3:0]  a4, b4;
  logic [7:0]  pr4 [3];

  int checks   = 0;
  int failures = 0;

  mult_seq_pipe #(.WIDTH(8), .STEP(1)) u8a (
    .clock(clk), .reset(rst), .start(st8[0]), .is_signed(sg8),
    .op_a(a8), .op_b(b8), .busy(bz8[0]), .done(dn8[0]),
    .product(pr8[0]), .overflow(ov8[0])
  );

  mult_seq_pipe #(.WIDTH(8), .STEP(4)) u8b (
    .clock(clk), .reset(rst), .start(st8[1]), .is_signed(sg8),
    .op_a(a8), .op_b(b8), .busy(bz8[1]), .done(dn8[1]),
    .product(pr8[1]), .overflow(ov8[1])
  );

  for (genvar g = 0; g < 3; g++) begin : g_w4
    mult_seq_pipe #(.WIDTH(4), .STEP(1 << g)) u4 (
      .clock(clk), .reset(rst), .start(st4[g]), .is_signed(sg4),
      .op_a(a4), .op_b(b4), .busy(bz4[g]), .done(dn4[g]),
      .product(pr4[g]), .overflow(ov4[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation on a WIDTH=8 instance; operands are scrambled after capture.
  task automatic run8(input string tag, input int sel, input logic s,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] ep, input logic eo);
    int cyc;
    int lat;
    lat = (sel == 0) ? 9 : 3;
    sg8 = s; a8 = a; b8 = b; st8[sel] = 1'b1;
    tick;
    chk({tag, "_busy"}, 64'(bz8[sel]), 64'd1);
    st8[sel] = 1'b0; sg8 = ~s; a8 = ~a; b8 = 8'h5A;
    cyc = 0;
    while (dn8[sel] !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_prod"}, 64'(pr8[sel]), 64'(ep));
    chk({tag, "_ovf"}, 64'(ov8[sel]), 64'(eo));
    chk({tag, "_busy_done"}, 64'(bz8[sel]), 64'd0);
    tick;
    chk({tag, "_done_pulse"}, 64'(dn8[sel]), 64'd0);
  endtask

  // Exhaustive WIDTH=4 sweep with start held high, so each new operation is
  // accepted on the previous done cycle.
  task automatic exh(input int g);
    int n, cyc, nd, ia, ib, p;
    logic [7:0] ep;
    logic eo;
    string tag;
    n = 4 >> g;
    st4[g] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          sg4 = m[0]; a4 = a[3:0]; b4 = b[3:0];
          ia = (m == 1 && a >= 8) ? a - 16 : a;
          ib = (m == 1 && b >= 8) ? b - 16 : b;
          p  = ia * ib;
          ep = 8'(p);
          eo = (m == 1) ? (p < -8 || p > 7) : (p > 15);
          tag = $sformatf("w4s%0d_m%0d_%0d_%0d", 1 << g, m, a, b);
          tick;
          cyc = 0;
          while (dn4[g] !== 1'b1 && cyc < 20) begin
            tick;
            cyc++;
          end
          chk({tag, "_lat"}, 64'(cyc), 64'(n + 1));
          chk({tag, "_prod"}, 64'(pr4[g]), 64'(ep));
          chk({tag, "_ovf"}, 64'(ov4[g]), 64'(eo));
        end
      end
    end
    st4[g] = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (dn4[g] === 1'b1) nd++;
    end
    chk($sformatf("w4s%0d_extra_done", 1 << g), 64'(nd), 64'd0);
  endtask

  initial begin
    int nd;
    rst = 1'b1; st8 = '0; st4 = '0; sg8 = 1'b0; sg4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    tick; tick;
    chk("rst_busy", 64'(bz8[0]), 64'd0);
    chk("rst_done", 64'(dn8[0]), 64'd0);
    chk("rst_prod", 64'(pr8[0]), 64'd0);
    chk("rst_ovf", 64'(ov8[0]), 64'd0);
    chk("rst_prod_s4", 64'(pr8[1]), 64'd0);
    rst = 1'b0;
    tick;

    run8("u200x3",    0, 1'b0, 8'd200, 8'd3,   16'h0258, 1'b1);
    run8("sm7x5",     0, 1'b1, 8'hF9,  8'd5,   16'hFFDD, 1'b0);
    run8("smin2",     0, 1'b1, 8'h80,  8'h80,  16'h4000, 1'b1);
    run8("s0xm1",     0, 1'b1, 8'h00,  8'hFF,  16'h0000, 1'b0);
    run8("s4_u255sq", 1, 1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b1);
    run8("s4_127xm1", 1, 1'b1, 8'h7F,  8'hFF,  16'hFF81, 1'b0);

    // Start and operand changes while busy must be ignored.
    sg8 = 1'b0; a8 = 8'd200; b8 = 8'd3; st8[0] = 1'b1;
    tick;
    st8[0] = 1'b0;
    tick; tick; tick;
    sg8 = 1'b1; a8 = 8'd10; b8 = 8'hF6; st8[0] = 1'b1;
    tick;
    st8[0] = 1'b0; a8 = 8'h00; b8 = 8'h00;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (dn8[0] === 1'b1) begin
        nd++;
        chk("ign_prod", 64'(pr8[0]), 64'h0258);
        chk("ign_ovf", 64'(ov8[0]), 64'd1);
      end
    end
    chk("ign_done_count", 64'(nd), 64'd1);

    // Reset three cycles into RUN discards the operation.
    sg8 = 1'b0; a8 = 8'd13; b8 = 8'd11; st8[0] = 1'b1;
    tick;
    st8[0] = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", 64'(bz8[0]), 64'd0);
    chk("mid_rst_done", 64'(dn8[0]), 64'd0);
    chk("mid_rst_prod", 64'(pr8[0]), 64'd0);
    chk("mid_rst_ovf", 64'(ov8[0]), 64'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (dn8[0] === 1'b1) nd++;
    end
    chk("mid_rst_no_done", 64'(nd), 64'd0);
    run8("rst_recover", 0, 1'b0, 8'd13, 8'd11, 16'h008F, 1'b0);

    exh(0);
    exh(1);
    exh(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
